// File: rtl/mem_stage_hs.sv
// rtl/mem_stage_hs.sv - EX/MEM stage with req/gnt/rvalid data-memory handshake.
// Optional MEM_STORE_FWD_EN adds late store-data forwarding (fwd_sel/fwd_data).
module mem_stage_hs #(
    parameter int DW   = 32,
    parameter int AW   = 32,
    parameter int RA_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DW-1:0]     in_alu_out,
    input  logic [DW-1:0]     in_fpu_out,
    input  logic [DW-1:0]     in_store_data,
    input  logic [DW-1:0]     in_pc4,
    input  logic [1:0]        in_din_src,
    input  logic              in_reg_we,
    input  logic [RA_W-1:0]   in_reg_waddr,
    input  logic              in_mem_re,
    input  logic              in_mem_we,
    input  logic [1:0]        in_mem_size,
    input  logic              in_mem_ext,
    input  logic              flush,
`ifdef MEM_STORE_FWD_EN
    input  logic              fwd_sel,
    input  logic [DW-1:0]     fwd_data,
`endif
    input  logic              dm_gnt,
    input  logic              dm_rvalid,
    input  logic [DW-1:0]     dm_rdata,
    output logic              stall_out,
    output logic              dm_req,
    output logic              dm_we,
    output logic [AW-1:0]     dm_addr,
    output logic [DW-1:0]     dm_wdata,
    output logic [DW/8-1:0]   dm_be,
    output logic              wb_valid,
    output logic [DW-1:0]     wb_data,
    output logic              wb_reg_we,
    output logic [RA_W-1:0]   wb_reg_waddr,
    output logic              misalign
);
    localparam int NB = DW / 8;
    localparam int LB = $clog2(NB);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

    state_t            state;
    logic              validQ, regWeQ, memReQ, memWeQ, extQ;
    logic [1:0]        dinSrcQ, sizeQ;
    logic [DW-1:0]     aluQ, fpuQ, storeQ, pc4Q;
    logic [RA_W-1:0]   regWaddrQ;
    logic [LB-1:0]     lane;
    logic              inAccess;
    logic [DW-1:0]     stSrc, rdSh, loadRaw, loadData;
    logic signed [DW-1:0] loadSx;
    int                shAmt, nBytes;

    // Byte 0 is the most significant byte, so lane k sits at bits [DW-1-8k -: 8].
    function automatic logic misF(input logic [LB-1:0] ln, input logic [1:0] size);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return ln[0];
            2'b10:   return ln[1:0] != 2'b00;
            default: return (DW == 32) ? 1'b1 : (ln != '0);
        endcase
    endfunction

    assign lane     = aluQ[LB-1:0];
    assign inAccess = in_valid & ~flush & (in_mem_re | in_mem_we)
                    & ~misF(in_alu_out[LB-1:0], in_mem_size);

    always_comb begin
        stall_out = 1'b0;
        case (state)
            REQ:     stall_out = ~(dm_gnt & memWeQ);
            WAIT:    stall_out = ~dm_rvalid;
            default: stall_out = 1'b0;
        endcase
    end

`ifdef MEM_STORE_FWD_EN
    logic firstQ;
    assign stSrc = (firstQ && fwd_sel) ? fwd_data : storeQ;
`else
    assign stSrc = storeQ;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            validQ    <= 1'b0;
            regWeQ    <= 1'b0;
            memReQ    <= 1'b0;
            memWeQ    <= 1'b0;
            extQ      <= 1'b0;
            dinSrcQ   <= 2'b00;
            sizeQ     <= 2'b00;
            aluQ      <= '0;
            fpuQ      <= '0;
            storeQ    <= '0;
            pc4Q      <= '0;
            regWaddrQ <= '0;
`ifdef MEM_STORE_FWD_EN
            firstQ    <= 1'b0;
`endif
        end else if (!stall_out) begin
            validQ    <= in_valid & ~flush;
            regWeQ    <= in_reg_we & ~flush;
            memReQ    <= in_mem_re & ~flush;
            memWeQ    <= in_mem_we & ~flush;
            extQ      <= in_mem_ext;
            dinSrcQ   <= in_din_src;
            sizeQ     <= in_mem_size;
            aluQ      <= in_alu_out;
            fpuQ      <= in_fpu_out;
            storeQ    <= in_store_data;
            pc4Q      <= in_pc4;
            regWaddrQ <= in_reg_waddr;
            state     <= inAccess ? REQ : IDLE;
`ifdef MEM_STORE_FWD_EN
            firstQ    <= 1'b1;
`endif
        end else begin
            // Stalled in REQ with a grant can only be a load.
            if (state == REQ && dm_gnt)
                state <= WAIT;
`ifdef MEM_STORE_FWD_EN
            if (firstQ && fwd_sel)
                storeQ <= fwd_data;
            firstQ <= 1'b0;
`endif
        end
    end

    assign dm_req  = (state == REQ);
    assign dm_we   = dm_req & memWeQ;
    assign dm_addr = dm_req ? (aluQ[AW-1:0] & ~AW'(NB - 1)) : '0;

    always_comb begin
        dm_wdata = '0;
        dm_be    = '0;
        nBytes   = 0;
        if (dm_req) begin
            case (sizeQ)
                2'b00:   begin dm_wdata = {NB{stSrc[7:0]}};          nBytes = 1;  end
                2'b01:   begin dm_wdata = {(DW/16){stSrc[15:0]}};    nBytes = 2;  end
                2'b10:   begin dm_wdata = {(DW/32){stSrc[31:0]}};    nBytes = 4;  end
                default: begin dm_wdata = stSrc;                     nBytes = NB; end
            endcase
            for (int k = 0; k < NB; k++)
                dm_be[k] = (k >= int'(lane)) && (k < int'(lane) + nBytes);
        end
    end

    // Shift the addressed lane to the top, then arithmetic/logical shift down to extend.
    assign rdSh = dm_rdata << {lane, 3'b000};

    always_comb begin
        shAmt = 0;
        case (sizeQ)
            2'b00:   shAmt = DW - 8;
            2'b01:   shAmt = DW - 16;
            2'b10:   shAmt = DW - 32;
            default: shAmt = 0;
        endcase
    end

    assign loadSx   = $signed(rdSh) >>> shAmt;
    assign loadRaw  = rdSh >> shAmt;
    assign loadData = extQ ? loadSx : loadRaw;

    always_comb begin
        wb_data = '0;
        case (dinSrcQ)
            2'b00:   wb_data = pc4Q;
            2'b01:   wb_data = aluQ;
            2'b10:   wb_data = fpuQ;
            default: wb_data = loadData;
        endcase
    end

    assign misalign     = validQ & (memReQ | memWeQ) & misF(lane, sizeQ);
    assign wb_valid     = validQ & ~stall_out;
    assign wb_reg_we    = regWeQ & validQ & ~misalign & ~stall_out;
    assign wb_reg_waddr = regWaddrQ;
endmodule
